bank_rw_arbiter: RTL



---
 rtl/bank_rw_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bank_rw_arbiter.sv
// Per-bank read/write arbiter: pops one FIFO head per cycle using write-drain
// hysteresis with a starvation override, and issues it through a one-entry stage tagged with row hit.
module bank_rw_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RA_POS       = 20,
  parameter int unsigned RA_BITS      = 10,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_valid_i,
  input  logic                  rd_mid_i,
  output logic                  rd_grant_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  input  logic                  wr_mid_i,
  output logic                  wr_grant_o,
  output logic [DATA_WIDTH-1:0] req_data_o,
  output logic                  req_is_wr_o,
  output logic                  req_hit_o,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [RA_BITS-1:0]    open_row_o,
  output logic                  mode_wr_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    READ_MODE   = 1'b0,
    WRITE_DRAIN = 1'b1
  } mode_t;

  mode_t                 r_mode;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic                  r_row_valid;
  logic [RA_BITS-1:0]    r_open_row;
  logic [DATA_WIDTH-1:0] r_req_data;
  logic                  r_req_is_wr;
  logic                  r_req_hit;
  logic                  r_req_valid;

  logic                  w_load_ok;
  logic                  w_pref_wr;
  logic                  w_pref_valid;
  logic                  w_np_valid;
  logic                  w_starved;
  logic                  w_take_np;
  logic                  w_take_pref;
  logic                  w_sel_rd;
  logic                  w_sel_wr;
  logic                  w_load;
  logic                  w_to_wr;
  logic                  w_to_rd;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [RA_BITS-1:0]    w_row;
  logic                  w_unused_rd_mid;

  // The read half-full flag is observed by the scheduler, not by arbitration.
  assign w_unused_rd_mid = rd_mid_i;

  assign w_load_ok    = !r_req_valid || req_ready_i;
  assign w_pref_wr    = (r_mode == WRITE_DRAIN);
  assign w_pref_valid = w_pref_wr ? wr_valid_i : rd_valid_i;
  assign w_np_valid   = w_pref_wr ? rd_valid_i : wr_valid_i;
  assign w_starved    = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Non-preferred side wins when starved, or as fallback when preferred is empty.
  assign w_take_np   = w_load_ok && w_np_valid && (w_starved || !w_pref_valid);
  assign w_take_pref = w_load_ok && w_pref_valid && !w_take_np;
  assign w_sel_wr    = w_pref_wr ? w_take_pref : w_take_np;
  assign w_sel_rd    = w_pref_wr ? w_take_np : w_take_pref;
  assign w_load      = w_sel_wr || w_sel_rd;
  assign w_sel_data  = w_sel_wr ? wr_data_i : rd_data_i;
  assign w_row       = w_sel_data[RA_POS +: RA_BITS];

  // Pops are suppressed while reset is held so nothing is lost from the FIFOs.
  assign rd_grant_o = w_sel_rd && rst_n;
  assign wr_grant_o = w_sel_wr && rst_n;

  assign w_to_wr = (r_mode == READ_MODE) && (wr_mid_i || (!rd_valid_i && wr_valid_i));
  assign w_to_rd = (r_mode == WRITE_DRAIN) && (!wr_valid_i || (!wr_mid_i && rd_valid_i));

  // Drain-mode FSM and starvation counter; mode change and np take both clear the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= READ_MODE;
      r_starve_cnt <= '0;
    end else begin
      if (w_to_wr) begin
        r_mode <= WRITE_DRAIN;
      end else if (w_to_rd) begin
        r_mode <= READ_MODE;
      end
      if (w_to_wr || w_to_rd || w_take_np) begin
        r_starve_cnt <= '0;
      end else if (w_take_pref && w_np_valid && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  // One-entry output stage with open-row tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_req_data  <= '0;
      r_req_is_wr <= 1'b0;
      r_req_hit   <= 1'b0;
      r_open_row  <= '0;
      r_row_valid <= 1'b0;
    end else if (w_load) begin
      r_req_valid <= 1'b1;
      r_req_data  <= w_sel_data;
      r_req_is_wr <= w_sel_wr;
      r_req_hit   <= r_row_valid && (w_row == r_open_row);
      r_open_row  <= w_row;
      r_row_valid <= 1'b1;
    end else if (req_ready_i) begin
      r_req_valid <= 1'b0;
    end
  end

  assign req_data_o  = r_req_data;
  assign req_is_wr_o = r_req_is_wr;
  assign req_hit_o   = r_req_hit;
  assign req_valid_o = r_req_valid;
  assign open_row_o  = r_open_row;
  assign mode_wr_o   = (r_mode == WRITE_DRAIN);

endmodule
